lms_tap_loader: RTL and testbench



---
 rtl/lms_tap_loader.sv | 93 +++++++++
 tb/tb_lms_tap_loader.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/lms_tap_loader.sv
// lms_tap_loader: pulls samples from the LMS FIFO into a TAP_NUM-deep delay line and presents each window via valid/ready.
module lms_tap_loader #(
    parameter int DATA_WIDTH = 16,
    parameter int TAP_NUM    = 32,
    parameter int TAP_IDX_W  = 5,
    parameter int FRAME_LEN  = 1024
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                  fifo_rd_empty,
    input  logic                  flush,
    output logic                  smp_valid,
    input  logic                  smp_ready,
    output logic [DATA_WIDTH-1:0] x_new,
    output logic [DATA_WIDTH-1:0] x_old,
    input  logic [TAP_IDX_W-1:0]  tap_rd_addr,
    output logic [DATA_WIDTH-1:0] tap_rd_data,
    output logic                  warm,
    output logic                  frame_start,
    output logic                  frame_end
);
    localparam int FILL_W = $clog2(TAP_NUM + 1);
    localparam int IDX_W  = $clog2(FRAME_LEN);
    typedef enum logic [1:0] {IDLE, FETCH, LOAD, PRESENT} state_t;
    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] taps_q [TAP_NUM];
    logic [DATA_WIDTH-1:0] x_new_q, x_old_q;
    logic [FILL_W-1:0]     fill_q;
    logic [IDX_W-1:0]      idx_q;
    logic                  smp_valid_q, frame_start_q, frame_end_q;
    logic                  load, accept;
    assign load        = (state_q == LOAD) && !flush;
    assign accept      = (state_q == PRESENT) && smp_ready;
    assign smp_valid   = smp_valid_q;
    assign x_new       = x_new_q;
    assign x_old       = x_old_q;
    assign warm        = (fill_q == FILL_W'(TAP_NUM));
    assign frame_start = frame_start_q;
    assign frame_end   = frame_end_q;
    always_comb begin
        fifo_rd_en = (state_q == FETCH) && !fifo_rd_empty && !flush;
        state_d    = flush                ? IDLE :
                     state_q == IDLE      ? (fifo_rd_empty ? IDLE : FETCH) :
                     state_q == FETCH     ? (fifo_rd_en ? LOAD : IDLE) :
                     state_q == LOAD      ? PRESENT :
                     smp_ready            ? (fifo_rd_empty ? IDLE : FETCH) : PRESENT;
    end
    // Indices at or beyond TAP_NUM fall through to zero
    always_comb begin
        tap_rd_data = '0;
        for (int i = 0; i < TAP_NUM; i++)
            if (int'(tap_rd_addr) == i) tap_rd_data = taps_q[i];
    end
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            state_q       <= IDLE;
            x_new_q       <= '0;
            x_old_q       <= '0;
            fill_q        <= '0;
            idx_q         <= '0;
            smp_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
            frame_end_q   <= 1'b0;
            for (int i = 0; i < TAP_NUM; i++) taps_q[i] <= '0;
        end else begin
            state_q <= state_d;
            if (flush) begin
                x_new_q       <= '0;
                x_old_q       <= '0;
                fill_q        <= '0;
                idx_q         <= '0;
                smp_valid_q   <= 1'b0;
                frame_start_q <= 1'b0;
                frame_end_q   <= 1'b0;
                for (int i = 0; i < TAP_NUM; i++) taps_q[i] <= '0;
            end else if (load) begin
                x_old_q <= taps_q[TAP_NUM-1];
                for (int i = 1; i < TAP_NUM; i++) taps_q[i] <= taps_q[i-1];
                taps_q[0]     <= fifo_rd_data;
                x_new_q       <= fifo_rd_data;
                fill_q        <= warm ? fill_q : fill_q + FILL_W'(1);
                frame_start_q <= (idx_q == '0);
                frame_end_q   <= (idx_q == IDX_W'(FRAME_LEN - 1));
                idx_q         <= (idx_q == IDX_W'(FRAME_LEN - 1)) ? '0 : idx_q + IDX_W'(1);
                smp_valid_q   <= 1'b1;
            end else if (accept) begin
                smp_valid_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_lms_tap_loader.sv
// tb_lms_tap_loader: directed checks of the tap loader with a 4-tap window and 4-sample frames.
module tb_lms_tap_loader;
    localparam int DW = 16, TN = 4, TW = 3, FL = 4;
    logic          clk = 1'b0, rst = 1'b1, flush = 1'b0, smp_ready = 1'b0;
    logic          fifo_rd_en, fifo_rd_empty, smp_valid, warm, frame_start, frame_end;
    logic [DW-1:0] fifo_rd_data = '0, x_new, x_old, tap_rd_data;
    logic [TW-1:0] tap_rd_addr = '0;
    logic [DW-1:0] mem [256];
    int            wp = 0, rp = 0, cyc = 0, rd_cyc = 0, rds = 0, bad_rd = 0;
    int            errs = 0, checks = 0, v_cyc = 0, r0, n;
    bit            stable;
    lms_tap_loader #(.DATA_WIDTH(DW), .TAP_NUM(TN), .TAP_IDX_W(TW), .FRAME_LEN(FL)) dut (
        .rd_clk(clk), .rd_rst(rst), .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data),
        .fifo_rd_empty(fifo_rd_empty), .flush(flush), .smp_valid(smp_valid), .smp_ready(smp_ready),
        .x_new(x_new), .x_old(x_old), .tap_rd_addr(tap_rd_addr), .tap_rd_data(tap_rd_data),
        .warm(warm), .frame_start(frame_start), .frame_end(frame_end)
    );
    always #5 clk = ~clk;
    assign fifo_rd_empty = (wp == rp);
    // FIFO read data appears one cycle after the enable, as with the real FIFO
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fifo_rd_en) begin
            fifo_rd_data <= mem[rp[7:0]];
            rp <= rp + 1;
        end
    end
    always @(negedge clk) begin
        if (fifo_rd_en) begin
            rds++;
            rd_cyc = cyc;
            if (fifo_rd_empty) bad_rd++;
        end
    end
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask
    task automatic push(input int v);
        mem[wp[7:0]] = DW'(v);
        wp++;
    endtask
    task automatic tick(input int k);
        repeat (k) begin
            @(negedge clk);
            #1;
        end
    endtask
    task automatic wait_valid(input string tag);
        int t = 0;
        do begin
            tick(1);
            t++;
        end while (!smp_valid && t < 30);
        if (!smp_valid) check({tag, " valid timeout"}, 32'(smp_valid), 1);
    endtask
    initial begin
        tick(2);
        check("rst valid", 32'(smp_valid), 0);
        check("rst rd_en", 32'(fifo_rd_en), 0);
        check("rst warm", 32'(warm), 0);
        check("rst x_new", 32'(x_new), 0);
        check("rst flags", {30'd0, frame_start, frame_end}, 0);
        for (int k = 1; k <= 6; k++) push(k);
        rst = 1'b0;
        smp_ready = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            wait_valid("fill");
            check($sformatf("x_new s%0d", k), 32'(x_new), 32'(k));
            check($sformatf("x_old s%0d", k), 32'(x_old), k > 4 ? 32'(k - 4) : 0);
            check($sformatf("warm s%0d", k), 32'(warm), 32'(k >= 4));
            check($sformatf("fstart s%0d", k), 32'(frame_start), 32'((k - 1) % 4 == 0));
            check($sformatf("fend s%0d", k), 32'(frame_end), 32'((k - 1) % 4 == 3));
            check($sformatf("latency s%0d", k), 32'(cyc - rd_cyc), 2);
            if (k > 1) check($sformatf("spacing s%0d", k), 32'(cyc - v_cyc), 3);
            v_cyc = cyc;
        end
        for (int a = 0; a < 8; a++) begin
            tap_rd_addr = TW'(a);
            #1;
            check($sformatf("tap%0d", a), 32'(tap_rd_data), a < 4 ? 32'(6 - a) : 0);
        end
        smp_ready = 1'b0;
        push(7); push(8); push(9);
        wait_valid("bp");
        check("bp x_new", 32'(x_new), 7);
        tap_rd_addr = 3'd1;
        r0 = rds;
        stable = 1'b1;
        repeat (10) begin
            tick(1);
            if (!smp_valid || x_new != 7 || tap_rd_data != 6) stable = 1'b0;
        end
        check("bp stable", 32'(stable), 1);
        check("bp no read", 32'(rds - r0), 0);
        r0 = rds;
        smp_ready = 1'b1;
        tick(1);
        smp_ready = 1'b0;
        tick(10);
        check("pulse one read", 32'(rds - r0), 1);
        check("pulse valid", 32'(smp_valid), 1);
        check("pulse x_new", 32'(x_new), 8);
        check("pulse fend", 32'(frame_end), 1);
        smp_ready = 1'b1;
        wait_valid("drain");
        check("drain x_new", 32'(x_new), 9);
        check("drain x_old", 32'(x_old), 5);
        check("drain fstart", 32'(frame_start), 1);
        r0 = rds;
        tick(10);
        check("idle no read", 32'(rds - r0), 0);
        push(10);
        wait_valid("resume");
        check("resume x_new", 32'(x_new), 10);
        check("resume fstart", 32'(frame_start), 0);
        tick(2);
        push(11);
        n = 0;
        do begin
            tick(1);
            n++;
        end while (!fifo_rd_en && n < 30);
        check("flush fetch seen", 32'(fifo_rd_en), 1);
        tick(1);
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        check("flush valid", 32'(smp_valid), 0);
        check("flush warm", 32'(warm), 0);
        check("flush x_new", 32'(x_new), 0);
        check("flush x_old", 32'(x_old), 0);
        for (int a = 0; a < 4; a++) begin
            tap_rd_addr = TW'(a);
            #1;
            check($sformatf("flush tap%0d", a), 32'(tap_rd_data), 0);
        end
        push(12);
        wait_valid("post flush");
        check("post flush x_new", 32'(x_new), 12);
        check("post flush fstart", 32'(frame_start), 1);
        check("post flush x_old", 32'(x_old), 0);
        check("post flush warm", 32'(warm), 0);
        tick(1);
        smp_ready = 1'b0;
        push(13);
        wait_valid("areset");
        check("areset pre x_new", 32'(x_new), 13);
        #2 rst = 1'b1;
        #1;
        check("areset valid", 32'(smp_valid), 0);
        check("areset x_new", 32'(x_new), 0);
        check("areset rd_en", 32'(fifo_rd_en), 0);
        check("rd_en while empty", 32'(bad_rd), 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
